// File: rtl/led_frame_sequencer_if.sv
// Frame-writer / pattern-logic side bundle of the LED frame sequencer.
// Latency: none, pure signal grouping.
// Backpressure: none; writes are always accepted, pixels are free-running.
interface led_frame_sequencer_if #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int NUM_FRAMES = 4
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int RW = $clog2(ROWS);

    logic                       en;
    logic [1:0]                 mode;
    logic [FW-1:0]              frame_sel;
    logic                       wr_en;
    logic [FW-1:0]              wr_frame;
    logic [RW-1:0]              wr_row;
    logic [COLS-1:0]            wr_red;
    logic [COLS-1:0]            wr_grn;
    logic [ROWS-1:0][COLS-1:0]  RedPixels;
    logic [ROWS-1:0][COLS-1:0]  GrnPixels;
    logic [FW-1:0]              frame_idx;
    logic                       tick;
    logic                       wrap;

    modport master (
        output en, mode, frame_sel, wr_en, wr_frame, wr_row, wr_red, wr_grn,
        input  RedPixels, GrnPixels, frame_idx, tick, wrap
    );

    modport slave (
        input  en, mode, frame_sel, wr_en, wr_frame, wr_row, wr_red, wr_grn,
        output RedPixels, GrnPixels, frame_idx, tick, wrap
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Stores NUM_FRAMES red/green frames and plays them as static, cycle, scroll or blink.
// Latency: state change at edge N shows on pixels after edge N+1; writes likewise.
// Backpressure: none; one row write per cycle always accepted, outputs free-running.
module led_frame_sequencer #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int NUM_FRAMES = 4,
    parameter int TICK_DIV   = 25_000_000
) (
    input logic                    CLK,
    input logic                    RST,
    led_frame_sequencer_if.slave   bus
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(TICK_DIV);

    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_CYCLE  = 2'd1,
        M_SCROLL = 2'd2,
        M_BLINK  = 2'd3
    } mode_e;

    mode_e                     mode_q, mode_in;
    logic [DW-1:0]             div_q, div_d;
    logic [RW-1:0]             off_q, off_d;
    logic                      blink_q, blink_d;
    logic [FW-1:0]             fidx_q, fidx_d;
    logic                      tick_q, tick_d;
    logic                      wrap_q, wrap_d;
    logic                      tick_evt;
    logic [FW-1:0]             sel_eff;
    logic                      wr_ok;

    logic [COLS-1:0]           red_mem [NUM_FRAMES][ROWS];
    logic [COLS-1:0]           grn_mem [NUM_FRAMES][ROWS];
    logic [ROWS-1:0][COLS-1:0] red_q, grn_q;

    // Stored row shown on display row r: content slides toward row 0 as offset grows.
    function automatic logic [RW-1:0] src_row(input int r, input logic [RW-1:0] off);
        int s;
        s = r + int'(off);
        if (s >= ROWS) s = s - ROWS;
        return RW'(s);
    endfunction

    // Out-of-range frame selects fall back to frame 0; out-of-range writes are dropped.
    always_comb begin
        mode_in = mode_e'(bus.mode);
        sel_eff = (32'(bus.frame_sel) < NUM_FRAMES) ? bus.frame_sel : '0;
        wr_ok   = bus.wr_en && (32'(bus.wr_frame) < NUM_FRAMES);
    end

    // Next-state: a mode change restarts the animation, otherwise the divider paces it.
    always_comb begin
        div_d    = div_q;
        off_d    = off_q;
        blink_d  = blink_q;
        fidx_d   = fidx_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        tick_evt = 1'b0;
        if (mode_in != mode_q) begin
            div_d   = '0;
            off_d   = '0;
            blink_d = 1'b1;
            fidx_d  = sel_eff;
        end else begin
            tick_evt = bus.en && (div_q == DIV_LAST);
            if (bus.en) div_d = tick_evt ? '0 : div_q + 1'b1;
            if (mode_q != M_CYCLE) fidx_d = sel_eff;
            if (tick_evt) begin
                tick_d = 1'b1;
                case (mode_q)
                    M_CYCLE: begin
                        fidx_d = (fidx_q == FRAME_LAST) ? '0 : fidx_q + 1'b1;
                        wrap_d = (fidx_q == FRAME_LAST);
                    end
                    M_SCROLL: begin
                        off_d  = (off_q == ROW_LAST) ? '0 : off_q + 1'b1;
                        wrap_d = (off_q == ROW_LAST);
                    end
                    M_BLINK: begin
                        blink_d = ~blink_q;
                        wrap_d  = ~blink_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Animation state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q  <= M_STATIC;
            div_q   <= '0;
            off_q   <= '0;
            blink_q <= 1'b1;
            fidx_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_in;
            div_q   <= div_d;
            off_q   <= off_d;
            blink_q <= blink_d;
            fidx_q  <= fidx_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    // Frame memory: cleared by reset, one row written per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int f = 0; f < NUM_FRAMES; f++) begin
                for (int r = 0; r < ROWS; r++) begin
                    red_mem[f][r] <= '0;
                    grn_mem[f][r] <= '0;
                end
            end
        end else if (wr_ok) begin
            red_mem[bus.wr_frame][bus.wr_row] <= bus.wr_red;
            grn_mem[bus.wr_frame][bus.wr_row] <= bus.wr_grn;
        end
    end

    // Registered pixel planes built from the current frame, offset and blink phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            red_q <= '0;
            grn_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                red_q[r] <= blink_q ? red_mem[fidx_q][src_row(r, off_q)] : '0;
                grn_q[r] <= blink_q ? grn_mem[fidx_q][src_row(r, off_q)] : '0;
            end
        end
    end

    assign bus.RedPixels = red_q;
    assign bus.GrnPixels = grn_q;
    assign bus.frame_idx = fidx_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized self-checking bench for led_frame_sequencer against a frame/offset model.
// Latency: model predicts pixels from the state one edge earlier.
// Backpressure: none; bench drives writes and mode changes freely.
module tb_led_frame_sequencer;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int NF   = 4;
    localparam int TD   = 4;
    localparam int FW   = 2;

    typedef logic [ROWS-1:0][COLS-1:0] plane_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [COLS-1:0] m_red [NF][ROWS];
    logic [COLS-1:0] m_grn [NF][ROWS];

    always #5 clk = ~clk;

    led_frame_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .NUM_FRAMES(NF)) bus ();
    led_frame_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .NUM_FRAMES(3))  bus3 ();

    led_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .NUM_FRAMES(NF), .TICK_DIV(TD)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    led_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .NUM_FRAMES(3), .TICK_DIV(TD)) dut3 (
        .CLK(clk), .RST(rst), .bus(bus3)
    );

    // Expected plane: frame f viewed through a scroll offset, blanked when invisible.
    function automatic plane_t exp_plane(input bit grn, input int f, input int off, input bit vis);
        plane_t p;
        for (int r = 0; r < ROWS; r++) begin
            if (!vis) p[r] = '0;
            else if (grn) p[r] = m_grn[f][(r + off) % ROWS];
            else p[r] = m_red[f][(r + off) % ROWS];
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < ROWS; r++) begin
                m_red[f][r] = '0;
                m_grn[f][r] = '0;
            end
    endtask

    task automatic write_row(input int f, input int r, input logic [COLS-1:0] red, input logic [COLS-1:0] grn);
        bus.wr_en    = 1'b1;
        bus.wr_frame = FW'(f);
        bus.wr_row   = 4'(r);
        bus.wr_red   = red;
        bus.wr_grn   = grn;
        step();
        bus.wr_en = 1'b0;
        m_red[f][r] = red;
        m_grn[f][r] = grn;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_frame = 1; bus.wr_row = 3;
        bus.wr_red = 16'hFFFF; bus.wr_grn = 16'hFFFF;
        bus.en = 1'b1; bus.mode = 0; bus.frame_sel = 1;
        step(); step();
        n_cmp++; if (bus.RedPixels !== '0) begin n_bad++; $display("FAIL reset_red got %h want 0", bus.RedPixels); end
        n_cmp++; if (bus.GrnPixels !== '0) begin n_bad++; $display("FAIL reset_grn got %h want 0", bus.GrnPixels); end
        n_cmp++; if (bus.frame_idx !== 2'd0) begin n_bad++; $display("FAIL reset_frame_idx got %0d want 0", bus.frame_idx); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", bus.tick); end
        n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
        rst = 1'b0; bus.wr_en = 1'b0; bus.en = 1'b0;
        for (int f = 0; f < NF; f++) begin
            bus.frame_sel = FW'(f);
            step(); step();
            n_cmp++; if (bus.RedPixels !== '0) begin n_bad++; $display("FAIL readback_red f%0d got %h want 0", f, bus.RedPixels); end
            n_cmp++; if (bus.GrnPixels !== '0) begin n_bad++; $display("FAIL readback_grn f%0d got %h want 0", f, bus.GrnPixels); end
        end
    endtask

    task automatic test_static_write();
        int f, r;
        bus.mode = 0; bus.en = 1'b0; bus.frame_sel = 1;
        step();
        write_row(1, 3, 16'hF00F, 16'h0FF0);
        n_cmp++; if (bus.RedPixels[3] !== 16'h0000) begin n_bad++; $display("FAIL write_early got %h want 0000", bus.RedPixels[3]); end
        step();
        n_cmp++; if (bus.RedPixels[3] !== 16'hF00F) begin n_bad++; $display("FAIL write_red3 got %h want F00F", bus.RedPixels[3]); end
        n_cmp++; if (bus.GrnPixels[3] !== 16'h0FF0) begin n_bad++; $display("FAIL write_grn3 got %h want 0FF0", bus.GrnPixels[3]); end
        n_cmp++; if (bus.RedPixels !== exp_plane(0, 1, 0, 1)) begin n_bad++; $display("FAIL write_red_plane got %h want %h", bus.RedPixels, exp_plane(0, 1, 0, 1)); end
        for (f = 0; f < NF; f++)
            for (r = 0; r < ROWS; r++)
                write_row(f, r, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 20; i++)
            write_row($urandom_range(0, NF - 1), $urandom_range(0, ROWS - 1), 16'($urandom), 16'($urandom));
        for (f = 0; f < NF; f++) begin
            bus.frame_sel = FW'(f);
            step(); step();
            n_cmp++; if (bus.RedPixels !== exp_plane(0, f, 0, 1)) begin n_bad++; $display("FAIL static_red f%0d got %h want %h", f, bus.RedPixels, exp_plane(0, f, 0, 1)); end
            n_cmp++; if (bus.GrnPixels !== exp_plane(1, f, 0, 1)) begin n_bad++; $display("FAIL static_grn f%0d got %h want %h", f, bus.GrnPixels, exp_plane(1, f, 0, 1)); end
        end
    endtask

    task automatic test_cycle();
        int edges, f, prev_f;
        bit en_now, t, w;
        plane_t pe;
        bus.frame_sel = 0; bus.mode = 1; bus.en = 1'b1;
        step();
        n_cmp++; if (bus.frame_idx !== 2'd0) begin n_bad++; $display("FAIL cycle_start got %0d want 0", bus.frame_idx); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL cycle_change_tick got %b want 0", bus.tick); end
        edges = 0; prev_f = 0;
        for (int i = 1; i <= 60; i++) begin
            en_now = (i <= 20) ? 1'b1 : (i <= 30) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.en = en_now;
            pe = exp_plane(0, prev_f, 0, 1);
            step();
            if (en_now) edges++;
            f = (edges / TD) % NF;
            t = en_now && (edges % TD == 0);
            w = t && (f == 0);
            n_cmp++; if (bus.frame_idx !== FW'(f)) begin n_bad++; $display("FAIL cycle_idx i%0d got %0d want %0d", i, bus.frame_idx, f); end
            n_cmp++; if (bus.tick !== t) begin n_bad++; $display("FAIL cycle_tick i%0d got %b want %b", i, bus.tick, t); end
            n_cmp++; if (bus.wrap !== w) begin n_bad++; $display("FAIL cycle_wrap i%0d got %b want %b", i, bus.wrap, w); end
            n_cmp++; if (bus.RedPixels !== pe) begin n_bad++; $display("FAIL cycle_red i%0d got %h want %h", i, bus.RedPixels, pe); end
            prev_f = f;
        end
    endtask

    task automatic test_scroll();
        int edges, off, prev_off;
        bit t, w, wr_now;
        plane_t pr, pg;
        bus.en = 1'b0;
        for (int r = 0; r < ROWS; r++)
            write_row(0, r, (r == 0) ? 16'h0001 : 16'h0000, 16'($urandom));
        bus.frame_sel = 0; bus.mode = 2; bus.en = 1'b1;
        step();
        edges = 0; prev_off = 0;
        for (int i = 1; i <= 68; i++) begin
            pr = exp_plane(0, 0, prev_off, 1);
            pg = exp_plane(1, 0, prev_off, 1);
            wr_now = (i == 40);
            if (wr_now) begin
                bus.wr_en = 1'b1; bus.wr_frame = 0; bus.wr_row = 5;
                bus.wr_red = 16'h0000; bus.wr_grn = 16'($urandom);
            end
            step();
            bus.wr_en = 1'b0;
            if (wr_now) begin m_red[0][5] = bus.wr_red; m_grn[0][5] = bus.wr_grn; end
            edges++;
            off = (edges / TD) % ROWS;
            t = (edges % TD == 0);
            w = t && (off == 0);
            n_cmp++; if (bus.tick !== t) begin n_bad++; $display("FAIL scroll_tick i%0d got %b want %b", i, bus.tick, t); end
            n_cmp++; if (bus.wrap !== w) begin n_bad++; $display("FAIL scroll_wrap i%0d got %b want %b", i, bus.wrap, w); end
            n_cmp++; if (bus.RedPixels !== pr) begin n_bad++; $display("FAIL scroll_red i%0d got %h want %h", i, bus.RedPixels, pr); end
            n_cmp++; if (bus.GrnPixels !== pg) begin n_bad++; $display("FAIL scroll_grn i%0d got %h want %h", i, bus.GrnPixels, pg); end
            n_cmp++; if (bus.RedPixels[(ROWS - prev_off) % ROWS] !== 16'h0001) begin n_bad++; $display("FAIL scroll_dot i%0d got %h want 0001", i, bus.RedPixels[(ROWS - prev_off) % ROWS]); end
            prev_off = off;
        end
    endtask

    task automatic test_blink();
        bit vis, prev_vis, t, w;
        plane_t pr;
        bus.frame_sel = 2; bus.mode = 3; bus.en = 1'b1;
        step();
        prev_vis = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            pr = exp_plane(0, 2, 0, prev_vis);
            step();
            vis = ((i / TD) % 2) == 0;
            t = (i % TD == 0);
            w = t && vis;
            n_cmp++; if (bus.RedPixels !== pr) begin n_bad++; $display("FAIL blink_red i%0d got %h want %h", i, bus.RedPixels, pr); end
            n_cmp++; if (bus.tick !== t) begin n_bad++; $display("FAIL blink_tick i%0d got %b want %b", i, bus.tick, t); end
            n_cmp++; if (bus.wrap !== w) begin n_bad++; $display("FAIL blink_wrap i%0d got %b want %b", i, bus.wrap, w); end
            n_cmp++; if (bus.frame_idx !== 2'd2) begin n_bad++; $display("FAIL blink_idx i%0d got %0d want 2", i, bus.frame_idx); end
            prev_vis = vis;
        end
        bus.mode = 0;
        step();
        n_cmp++; if (bus.RedPixels !== '0) begin n_bad++; $display("FAIL blink_exit_dark got %h want 0", bus.RedPixels); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL blink_exit_tick got %b want 0", bus.tick); end
        step();
        n_cmp++; if (bus.RedPixels !== exp_plane(0, 2, 0, 1)) begin n_bad++; $display("FAIL blink_exit_red got %h want %h", bus.RedPixels, exp_plane(0, 2, 0, 1)); end
        n_cmp++; if (bus.GrnPixels !== exp_plane(1, 2, 0, 1)) begin n_bad++; $display("FAIL blink_exit_grn got %h want %h", bus.GrnPixels, exp_plane(1, 2, 0, 1)); end
        for (int j = 2; j <= 4; j++) begin
            step();
            n_cmp++; if (bus.tick !== (j == 4)) begin n_bad++; $display("FAIL blink_div_restart j%0d got %b want %b", j, bus.tick, (j == 4)); end
        end
    endtask

    task automatic test_reset_mid_scroll();
        bus.frame_sel = 0; bus.mode = 2; bus.en = 1'b1;
        step();
        for (int i = 1; i <= 29; i++) step();
        n_cmp++; if (bus.RedPixels !== exp_plane(0, 0, 7, 1)) begin n_bad++; $display("FAIL scroll_off7 got %h want %h", bus.RedPixels, exp_plane(0, 0, 7, 1)); end
        rst = 1'b1; bus.mode = 0;
        step();
        clear_model();
        n_cmp++; if (bus.RedPixels !== '0) begin n_bad++; $display("FAIL midrst_red got %h want 0", bus.RedPixels); end
        n_cmp++; if (bus.GrnPixels !== '0) begin n_bad++; $display("FAIL midrst_grn got %h want 0", bus.GrnPixels); end
        n_cmp++; if (bus.frame_idx !== 2'd0) begin n_bad++; $display("FAIL midrst_idx got %0d want 0", bus.frame_idx); end
        n_cmp++; if (bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin n_bad++; $display("FAIL midrst_tickwrap got %b%b want 00", bus.tick, bus.wrap); end
        rst = 1'b0; bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin n_bad++; $display("FAIL postrst_tickwrap i%0d got %b%b want 00", i, bus.tick, bus.wrap); end
            n_cmp++; if (bus.RedPixels !== '0) begin n_bad++; $display("FAIL postrst_mem got %h want 0", bus.RedPixels); end
        end
        write_row(0, 0, 16'h0001, 16'h8000);
        step();
        n_cmp++; if (bus.RedPixels !== exp_plane(0, 0, 0, 1)) begin n_bad++; $display("FAIL postrst_off0_red got %h want %h", bus.RedPixels, exp_plane(0, 0, 0, 1)); end
        n_cmp++; if (bus.GrnPixels !== exp_plane(1, 0, 0, 1)) begin n_bad++; $display("FAIL postrst_off0_grn got %h want %h", bus.GrnPixels, exp_plane(1, 0, 0, 1)); end
    endtask

    task automatic test_out_of_range();
        plane_t pr;
        bus3.wr_en = 1'b1; bus3.wr_frame = 2'd3; bus3.wr_row = 2;
        bus3.wr_red = 16'hAAAA; bus3.wr_grn = 16'h5555;
        step();
        bus3.wr_frame = 2'd0; bus3.wr_red = 16'h1234; bus3.wr_grn = 16'h4321;
        step();
        bus3.wr_en = 1'b0; bus3.frame_sel = 2'd3;
        step(); step();
        pr = '0; pr[2] = 16'h1234;
        n_cmp++; if (bus3.frame_idx !== 2'd0) begin n_bad++; $display("FAIL oor_sel_idx got %0d want 0", bus3.frame_idx); end
        n_cmp++; if (bus3.RedPixels !== pr) begin n_bad++; $display("FAIL oor_sel_red got %h want %h", bus3.RedPixels, pr); end
        n_cmp++; if (bus3.GrnPixels[2] !== 16'h4321) begin n_bad++; $display("FAIL oor_sel_grn got %h want 4321", bus3.GrnPixels[2]); end
        for (int f = 1; f < 3; f++) begin
            bus3.frame_sel = 2'(f);
            step(); step();
            n_cmp++; if (bus3.frame_idx !== 2'(f)) begin n_bad++; $display("FAIL oor_idx f%0d got %0d want %0d", f, bus3.frame_idx, f); end
            n_cmp++; if (bus3.RedPixels !== '0 || bus3.GrnPixels !== '0) begin n_bad++; $display("FAIL oor_dropped f%0d got %h want 0", f, bus3.RedPixels); end
        end
    endtask

    initial begin
        clear_model();
        bus.en = 1'b0; bus.mode = 0; bus.frame_sel = 0; bus.wr_en = 1'b0;
        bus.wr_frame = 0; bus.wr_row = 0; bus.wr_red = '0; bus.wr_grn = '0;
        bus3.en = 1'b0; bus3.mode = 0; bus3.frame_sel = 0; bus3.wr_en = 1'b0;
        bus3.wr_frame = 0; bus3.wr_row = 0; bus3.wr_red = '0; bus3.wr_grn = '0;
        test_reset();
        test_static_write();
        test_cycle();
        test_scroll();
        test_blink();
        test_reset_mid_scroll();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
